// File: rtl/gmii_tx_fcs_ctrl_if.sv
// Byte-stream input and GMII output bundle for the TX frame sequencer.
// Handshake: a byte transfers on a rising clk edge where s_valid && s_ready are both high;
// the source holds s_data/s_last stable while s_valid is high and the byte is not yet taken.
interface gmii_tx_fcs_ctrl_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       frame_done;
  logic       underrun;

  modport master (output s_data, s_valid, s_last,
                  input  s_ready, gmii_txd, gmii_tx_en, gmii_tx_er, frame_done, underrun);
  modport slave  (input  s_data, s_valid, s_last,
                  output s_ready, gmii_txd, gmii_tx_en, gmii_tx_er, frame_done, underrun);
endinterface

// File: rtl/gmii_tx_fcs_ctrl.sv
// GMII TX frame sequencer: preamble/SFD, payload, zero pad, CRC-32 FCS, inter-frame gap,
// and underrun abort. All GMII outputs and s_ready are registered.
module gmii_tx_fcs_ctrl #(
  parameter int MIN_FRAME    = 60,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic              clk,
  input  logic              reset_p,
  gmii_tx_fcs_ctrl_if.slave bus,
  output logic [2:0]        dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_DROP, S_IFG
  } state_t;

  localparam logic [10:0] CNT_MAX  = 11'd2047;
  localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
  localparam logic [15:0] PRE_LEN  = 16'(PREAMBLE_LEN);
  localparam logic [15:0] IFG_LEN  = 16'(IFG_CYCLES);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  state_t      state;
  logic [31:0] crc;
  logic [10:0] byte_cnt;
  logic [15:0] cnt;
  logic [10:0] byte_cnt_inc;
  logic [31:0] crc_data;
  logic [31:0] crc_pad;
  logic [31:0] fcs;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    byte_cnt_inc = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;
    crc_data     = crc_step(crc, bus.s_data);
    crc_pad      = crc_step(crc, 8'h00);
    fcs          = ~crc;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state          <= S_IDLE;
      crc            <= '1;
      byte_cnt       <= '0;
      cnt            <= '0;
      bus.s_ready    <= 1'b0;
      bus.gmii_txd   <= 8'h00;
      bus.gmii_tx_en <= 1'b0;
      bus.gmii_tx_er <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.underrun   <= 1'b0;
    end else begin
      bus.gmii_tx_er <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.underrun   <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.s_ready    <= 1'b0;
          bus.gmii_txd   <= 8'h00;
          bus.gmii_tx_en <= 1'b0;
          if (bus.s_valid) begin
            state          <= S_PRE;
            crc            <= '1;
            byte_cnt       <= '0;
            cnt            <= 16'd1;
            bus.gmii_txd   <= 8'h55;
            bus.gmii_tx_en <= 1'b1;
          end
        end
        // s_ready goes up together with the SFD so the first byte lands right after it
        S_PRE: begin
          if (cnt < PRE_LEN) begin
            bus.gmii_txd <= 8'h55;
            cnt          <= cnt + 16'd1;
          end else begin
            bus.gmii_txd <= 8'hD5;
            bus.s_ready  <= 1'b1;
            state        <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.s_valid) begin
            bus.gmii_txd <= bus.s_data;
            crc          <= crc_data;
            byte_cnt     <= byte_cnt_inc;
            if (bus.s_last) begin
              bus.s_ready <= 1'b0;
              cnt         <= '0;
              state       <= ({1'b0, byte_cnt_inc} < MIN_LEN) ? S_PAD : S_FCS;
            end
          end else begin
            bus.gmii_txd   <= 8'h00;
            bus.gmii_tx_er <= 1'b1;
            bus.underrun   <= 1'b1;
            state          <= S_DROP;
          end
        end
        S_PAD: begin
          bus.gmii_txd <= 8'h00;
          crc          <= crc_pad;
          byte_cnt     <= byte_cnt_inc;
          if ({1'b0, byte_cnt_inc} >= MIN_LEN) state <= S_FCS;
        end
        S_FCS: begin
          case (cnt[1:0])
            2'd0:    bus.gmii_txd <= fcs[7:0];
            2'd1:    bus.gmii_txd <= fcs[15:8];
            2'd2:    bus.gmii_txd <= fcs[23:16];
            default: bus.gmii_txd <= fcs[31:24];
          endcase
          if (cnt[1:0] == 2'd3) begin
            bus.frame_done <= 1'b1;
            cnt            <= '0;
            state          <= S_IFG;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DROP: begin
          bus.gmii_tx_en <= 1'b0;
          bus.gmii_txd   <= 8'h00;
          if (bus.s_valid && bus.s_last) begin
            bus.s_ready <= 1'b0;
            cnt         <= '0;
            state       <= S_IFG;
          end
        end
        // first IFG cycle still shows the last byte, so count one extra before IDLE
        S_IFG: begin
          bus.gmii_tx_en <= 1'b0;
          bus.gmii_txd   <= 8'h00;
          bus.s_ready    <= 1'b0;
          if (cnt >= IFG_LEN) state <= S_IDLE;
          else                cnt   <= cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gmii_tx_fcs_ctrl.sv
// Randomised bench for gmii_tx_fcs_ctrl: expected GMII byte stream per frame built from the
// framing rules, compared on every negedge; a MIN_FRAME=0 instance pins the check-value frame.
module tb_gmii_tx_fcs_ctrl;
  localparam int MIN_FRAME = 60;
  localparam int PRE_LEN   = 7;
  localparam int IFG       = 12;
  localparam logic [2:0] K_PRE = 3'd0, K_SFD = 3'd1, K_DATA = 3'd2, K_PAD = 3'd3;

  typedef struct packed {
    logic [7:0] d;
    logic       er;
    logic       done;
    logic       urun;
    logic       rdy;
    logic       last;
    logic [2:0] kind;
  } item_t;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic reset_p;
  logic sel0;
  logic [2:0] dbg_state, dbg_state0;
  always #4 clk = ~clk;

  gmii_tx_fcs_ctrl_if bus ();
  gmii_tx_fcs_ctrl_if bus0 ();
  assign bus0.s_data  = bus.s_data;
  assign bus0.s_last  = bus.s_last;
  assign bus0.s_valid = bus.s_valid & sel0;

  gmii_tx_fcs_ctrl u_dut (.clk(clk), .reset_p(reset_p), .bus(bus), .dbg_state(dbg_state));
  gmii_tx_fcs_ctrl #(.MIN_FRAME(0)) u_dut0 (.clk(clk), .reset_p(reset_p), .bus(bus0),
                                            .dbg_state(dbg_state0));

  // ---------------- scoreboard state ----------------
  item_t      exp_q[$];
  logic [7:0] pay[$];
  logic [7:0] cap0[$];
  int         done_pos0 = 0;
  int         n_pass = 0, n_total = 0;
  int         gap_cnt = 100, last_gap = 0;
  logic       prev_en = 1'b0, prev_last = 1'b1;
  logic [2:0] last_kind = 3'd0;
  bit         mon_en = 1'b0, dropping = 1'b0;
  item_t      it;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic finish_report();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: got no DUT response expected one within the cycle budget", name);
    finish_report();
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] crc_model(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[i])
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  function automatic item_t mk(input logic [7:0] d, input logic er, input logic done,
                               input logic urun, input logic rdy, input logic last,
                               input logic [2:0] kind);
    item_t r;
    r.d = d; r.er = er; r.done = done; r.urun = urun; r.rdy = rdy; r.last = last; r.kind = kind;
    return r;
  endfunction

  task automatic push_frame(input int stall_at);
    logic [7:0]  fr[$];
    logic [31:0] fcs;
    int          n;
    n = pay.size();
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(mk(8'h55, 0, 0, 0, 0, 0, K_PRE));
    exp_q.push_back(mk(8'hD5, 0, 0, 0, 1, 0, K_SFD));
    if (stall_at < 0) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(mk(pay[i], 0, 0, 0, i < n - 1, 0, K_DATA));
        fr.push_back(pay[i]);
      end
      while (fr.size() < MIN_FRAME) begin
        fr.push_back(8'h00);
        exp_q.push_back(mk(8'h00, 0, 0, 0, 0, 0, K_PAD));
      end
      fcs = ~crc_model(fr);
      for (int k = 0; k < 4; k++)
        exp_q.push_back(mk(fcs[8*k +: 8], 0, k == 3, 0, 0, k == 3, 3'(4 + k)));
    end else begin
      for (int i = 0; i < stall_at; i++) exp_q.push_back(mk(pay[i], 0, 0, 0, 1, 0, K_DATA));
      exp_q.push_back(mk(8'h00, 1, 0, 1, 1, 1, K_DATA));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic last);
    logic acc;
    int   w;
    w = 0;
    bus.s_data = d; bus.s_last = last; bus.s_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
      w++;
      if (w > 3000 && !acc) timeout("handshake");
    end while (!acc);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic send_frame(input int stall_at);
    int n;
    n = pay.size();
    push_frame(stall_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        dropping = 1'b1;
        idle($urandom_range(1, 4));
      end
      drive_byte(pay[i], i == n - 1);
    end
    dropping = 1'b0;
  endtask

  task automatic rand_payload(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"},    32'(bus.s_ready),    0);
    chk({tag, "_txd"},        32'(bus.gmii_txd),   0);
    chk({tag, "_tx_en"},      32'(bus.gmii_tx_en), 0);
    chk({tag, "_tx_er"},      32'(bus.gmii_tx_er), 0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    chk({tag, "_underrun"},   32'(bus.underrun),   0);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.gmii_tx_en) begin
        if (exp_q.size() == 0) begin
          chk("tx_en_without_expected_byte", 32'(exp_q.size()), 1);
        end else begin
          it = exp_q.pop_front();
          if (!prev_en) begin
            chk("ifg_min_13", 32'(gap_cnt >= IFG + 1), 1);
            last_gap = gap_cnt;
          end
          chk("wire_txd_er_done_urun_rdy",
              {20'h0, bus.gmii_txd, bus.gmii_tx_er, bus.frame_done, bus.underrun, bus.s_ready},
              {20'h0, it.d, it.er, it.done, it.urun, it.rdy});
          prev_last = it.last;
          last_kind = it.kind;
        end
        gap_cnt = 0;
      end else begin
        if (prev_en) chk("burst_end_on_last_item", 32'(prev_last), 1);
        chk("idle_er_done_urun_rdy",
            {28'h0, bus.gmii_tx_er, bus.frame_done, bus.underrun, bus.s_ready},
            {28'h0, 3'b000, dropping});
        gap_cnt++;
      end
      prev_en = bus.gmii_tx_en;
    end
  end

  always @(negedge clk) begin
    if (bus0.gmii_tx_en) begin
      cap0.push_back(bus0.gmii_txd);
      if (bus0.frame_done) done_pos0 = cap0.size();
    end
  end

  initial begin
    #400000;
    n_total++;
    $display("FAIL watchdog: got no end of test expected one before 400 us");
    finish_report();
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [7:0] exp0[21];
    int w, n, st;
    bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    sel0 = 1'b1; reset_p = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset_p = 1'b0;
    mon_en  = 1'b1;

    // check-value frame on both instances
    pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc32_123456789", ~crc_model(pay), 32'hCBF43926);
    send_frame(-1);
    sel0 = 1'b0;
    idle(4);

    rand_payload(14);  send_frame(-1); idle(6);
    rand_payload(100); send_frame(-1);
    rand_payload(30);  send_frame(-1);
    chk("back_to_back_gap", 32'(last_gap), 13);

    for (int i = 0; i < 7; i++) exp0[i] = 8'h55;
    exp0[7] = 8'hD5;
    for (int i = 0; i < 9; i++) exp0[8 + i] = 8'(8'h31 + i);
    exp0[17] = 8'h26; exp0[18] = 8'h39; exp0[19] = 8'hF4; exp0[20] = 8'hCB;
    chk("min0_tx_en_cycles", 32'(cap0.size()), 21);
    for (int i = 0; i < 21; i++)
      if (i < cap0.size()) chk($sformatf("min0_byte%0d", i), 32'(cap0[i]), 32'(exp0[i]));
    chk("min0_frame_done_pos", 32'(done_pos0), 21);

    idle(3);
    rand_payload(40); send_frame(20);
    idle(2);

    // reset while the second FCS byte is on the wire
    rand_payload(25); last_kind = 3'd0; send_frame(-1);
    w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (last_kind != 3'd5 && w < 300);
    if (w >= 300) timeout("fcs_byte2");
    mon_en  = 1'b0;
    reset_p = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_p = 1'b0;
    gap_cnt = 100; prev_en = 1'b0; prev_last = 1'b1;
    mon_en  = 1'b1;
    rand_payload(10); send_frame(-1);

    for (int f = 0; f < 14; f++) begin
      n  = $urandom_range(1, 120);
      st = -1;
      if (n >= 2 && $urandom_range(0, 3) == 0) st = $urandom_range(1, n - 1);
      rand_payload(n);
      send_frame(st);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
    end

    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (20) @(negedge clk);
    chk("all_expected_bytes_seen", 32'(exp_q.size()), 0);
    finish_report();
  end
endmodule
